// File: rtl/mux_skid_sel.sv
// N-channel select mux feeding a 2-entry skid buffer with valid/ready on both sides.
// Define MUX_SKID_ONEHOT_EN for a CH-bit one-hot select instead of a binary one.
module mux_skid_sel #(
  parameter int WIDTH = 32,
  parameter int SEL_W = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [(2**SEL_W)*WIDTH-1:0]   in_data,
`ifdef MUX_SKID_ONEHOT_EN
  input  logic [(2**SEL_W)-1:0]         sel,
`else
  input  logic [SEL_W-1:0]              sel,
`endif
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [WIDTH-1:0]              out_data,
  output logic [SEL_W-1:0]              out_sel,
  output logic                          out_valid,
  input  logic                          out_ready
);

  localparam int CH = 2**SEL_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   main_data_q, main_data_d;
  logic [SEL_W-1:0]   main_sel_q, main_sel_d;
  logic [WIDTH-1:0]   skid_data_q, skid_data_d;
  logic [SEL_W-1:0]   skid_sel_q, skid_sel_d;

  logic [WIDTH-1:0]   new_data;
  logic [SEL_W-1:0]   new_sel;
  logic               accept;
  logic               pop;

`ifdef MUX_SKID_ONEHOT_EN
  // AND-OR selection; the reported index is the lowest set select bit.
  always_comb begin
    new_data = '0;
    new_sel  = '0;
    for (int i = 0; i < CH; i++) begin
      if (sel[i]) new_data = new_data | in_data[i*WIDTH +: WIDTH];
    end
    for (int i = CH - 1; i >= 0; i--) begin
      if (sel[i]) new_sel = SEL_W'(i);
    end
  end
`else
  always_comb begin
    new_data = '0;
    new_sel  = sel;
    for (int i = 0; i < CH; i++) begin
      if (sel == SEL_W'(i)) new_data = in_data[i*WIDTH +: WIDTH];
    end
  end
`endif

  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_data_q;
  assign out_sel   = main_sel_q;

  assign accept = in_valid & in_ready & ~rst & ~flush;
  assign pop    = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_sel_d  = main_sel_q;
    skid_data_d = skid_data_q;
    skid_sel_d  = skid_sel_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          main_data_d = new_data;
          main_sel_d  = new_sel;
          state_d     = ONE;
        end
      end
      ONE: begin
        if (accept && pop) begin
          main_data_d = new_data;
          main_sel_d  = new_sel;
        end else if (accept) begin
          skid_data_d = new_data;
          skid_sel_d  = new_sel;
          state_d     = TWO;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          main_data_d = skid_data_q;
          main_sel_d  = skid_sel_q;
          state_d     = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush only drops occupancy; stale register contents are hidden by out_valid=0.
    if (flush) state_d = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_sel_q  <= '0;
      skid_data_q <= '0;
      skid_sel_q  <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_sel_q  <= main_sel_d;
      skid_data_q <= skid_data_d;
      skid_sel_q  <= skid_sel_d;
    end
  end

endmodule

// File: tb/tb_mux_skid_sel.sv
// Directed self-checking bench for mux_skid_sel; also covers the one-hot select
// build when MUX_SKID_ONEHOT_EN is defined.
module tb_mux_skid_sel;

  localparam int WIDTH = 32;
  localparam int SEL_W = 2;
  localparam int CH    = 2**SEL_W;
`ifdef MUX_SKID_ONEHOT_EN
  localparam int SIN_W = CH;
`else
  localparam int SIN_W = SEL_W;
`endif

  logic                  clk;
  logic                  rst;
  logic                  flush;
  logic [CH*WIDTH-1:0]   in_data;
  logic [SIN_W-1:0]      sel;
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      out_data;
  logic [SEL_W-1:0]      out_sel;
  logic                  out_valid;
  logic                  out_ready;

  int nAsserts = 0;
  int nFails   = 0;

  mux_skid_sel #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_data   (in_data),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Select encoding for a single channel in whichever select mode is built.
  function automatic logic [SIN_W-1:0] selFor(input int ch);
`ifdef MUX_SKID_ONEHOT_EN
    logic [SIN_W-1:0] s;
    s = '0;
    s[ch] = 1'b1;
    return s;
`else
    return SIN_W'(ch);
`endif
  endfunction

  // Drive one cycle of inputs (other channels carry filler), then advance to the next falling edge.
  task automatic applyStimulus(input logic v, input int ch, input logic [WIDTH-1:0] val,
                               input logic ordy, input logic fl);
    for (int i = 0; i < CH; i++) in_data[i*WIDTH +: WIDTH] = 32'hBAD0_0000 | 32'(i);
    in_data[ch*WIDTH +: WIDTH] = val;
    sel       = selFor(ch);
    in_valid  = v;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Output data/sel are compared only when a valid head is expected.
  task automatic checkOutput(input string tag, input logic ev, input logic [WIDTH-1:0] ed,
                             input logic [SEL_W-1:0] es, input logic er);
    nAsserts++;
    assert (out_valid === ev) else begin
      nFails++;
      $error("[TB] FAIL %s out_valid got %0b want %0b", tag, out_valid, ev);
    end
    nAsserts++;
    assert (in_ready === er) else begin
      nFails++;
      $error("[TB] FAIL %s in_ready got %0b want %0b", tag, in_ready, er);
    end
    if (ev) begin
      nAsserts++;
      assert (out_data === ed) else begin
        nFails++;
        $error("[TB] FAIL %s out_data got %h want %h", tag, out_data, ed);
      end
      nAsserts++;
      assert (out_sel === es) else begin
        nFails++;
        $error("[TB] FAIL %s out_sel got %0d want %0d", tag, out_sel, es);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    // Reset held two cycles with a transfer offered; nothing may be captured.
    applyStimulus(1'b1, 1, 32'h5A, 1'b0, 1'b0);
    applyStimulus(1'b1, 1, 32'h5A, 1'b0, 1'b0);
    rst = 1'b0;
    in_valid = 1'b0;
    checkOutput("reset", 1'b0, '0, '0, 1'b1);
    nAsserts++;
    assert (out_data === 32'h0 && out_sel === 2'd0) else begin
      nFails++;
      $error("[TB] FAIL reset_regs out_data %h out_sel %0d want 0 0", out_data, out_sel);
    end
    applyStimulus(1'b0, 0, 32'h0, 1'b1, 1'b0);
    checkOutput("reset_idle", 1'b0, '0, '0, 1'b1);

    // Streaming, one per cycle.
    applyStimulus(1'b1, 0, 32'hA0, 1'b1, 1'b0);
    checkOutput("stream0", 1'b1, 32'hA0, 2'd0, 1'b1);
    applyStimulus(1'b1, 1, 32'hB1, 1'b1, 1'b0);
    checkOutput("stream1", 1'b1, 32'hB1, 2'd1, 1'b1);
    applyStimulus(1'b1, 2, 32'hC2, 1'b1, 1'b0);
    checkOutput("stream2", 1'b1, 32'hC2, 2'd2, 1'b1);
    applyStimulus(1'b1, 3, 32'hD3, 1'b1, 1'b0);
    checkOutput("stream3", 1'b1, 32'hD3, 2'd3, 1'b1);
    applyStimulus(1'b0, 0, 32'h0, 1'b1, 1'b0);
    checkOutput("stream_drain", 1'b0, '0, '0, 1'b1);

    // Back-pressure fills the skid and holds the third offer off.
    applyStimulus(1'b1, 1, 32'h11, 1'b0, 1'b0);
    checkOutput("bp_one", 1'b1, 32'h11, 2'd1, 1'b1);
    applyStimulus(1'b1, 2, 32'h22, 1'b0, 1'b0);
    checkOutput("bp_two", 1'b1, 32'h11, 2'd1, 1'b0);
    applyStimulus(1'b1, 3, 32'h33, 1'b0, 1'b0);
    checkOutput("bp_hold", 1'b1, 32'h11, 2'd1, 1'b0);
    applyStimulus(1'b1, 3, 32'h33, 1'b1, 1'b0);
    checkOutput("bp_pop1", 1'b1, 32'h22, 2'd2, 1'b1);
    applyStimulus(1'b1, 3, 32'h33, 1'b1, 1'b0);
    checkOutput("bp_pop2", 1'b1, 32'h33, 2'd3, 1'b1);
    applyStimulus(1'b0, 0, 32'h0, 1'b1, 1'b0);
    checkOutput("bp_drain", 1'b0, '0, '0, 1'b1);

    // Flush from TWO with a transfer offered.
    applyStimulus(1'b1, 0, 32'h44, 1'b0, 1'b0);
    applyStimulus(1'b1, 1, 32'h55, 1'b0, 1'b0);
    checkOutput("fl_full", 1'b1, 32'h44, 2'd0, 1'b0);
    applyStimulus(1'b1, 2, 32'h66, 1'b0, 1'b1);
    checkOutput("fl_two", 1'b0, '0, '0, 1'b1);
    applyStimulus(1'b0, 0, 32'h0, 1'b1, 1'b0);
    checkOutput("fl_two_after", 1'b0, '0, '0, 1'b1);

    // Flush from ONE overrides an accept that would otherwise happen.
    applyStimulus(1'b1, 3, 32'h99, 1'b0, 1'b0);
    checkOutput("fl_one_pre", 1'b1, 32'h99, 2'd3, 1'b1);
    applyStimulus(1'b1, 2, 32'h66, 1'b1, 1'b1);
    checkOutput("fl_one", 1'b0, '0, '0, 1'b1);
    applyStimulus(1'b0, 0, 32'h0, 1'b1, 1'b0);
    checkOutput("fl_one_after", 1'b0, '0, '0, 1'b1);

    // Simultaneous accept and pop in ONE.
    applyStimulus(1'b1, 3, 32'h77, 1'b0, 1'b0);
    checkOutput("ap_head", 1'b1, 32'h77, 2'd3, 1'b1);
    applyStimulus(1'b1, 0, 32'h88, 1'b1, 1'b0);
    checkOutput("ap_swap", 1'b1, 32'h88, 2'd0, 1'b1);
    applyStimulus(1'b0, 0, 32'h0, 1'b1, 1'b0);
    checkOutput("ap_drain", 1'b0, '0, '0, 1'b1);

    // Reset mid-transfer discards both entries even with flush also high.
    applyStimulus(1'b1, 1, 32'hAA, 1'b0, 1'b0);
    applyStimulus(1'b1, 2, 32'hBB, 1'b0, 1'b0);
    rst = 1'b1;
    applyStimulus(1'b1, 3, 32'hCC, 1'b0, 1'b1);
    rst = 1'b0;
    checkOutput("mid_rst", 1'b0, '0, '0, 1'b1);
    nAsserts++;
    assert (out_data === 32'h0 && out_sel === 2'd0) else begin
      nFails++;
      $error("[TB] FAIL mid_rst_regs out_data %h out_sel %0d want 0 0", out_data, out_sel);
    end

`ifdef MUX_SKID_ONEHOT_EN
    // Multi-hot and all-zero one-hot selects.
    for (int i = 0; i < CH; i++) in_data[i*WIDTH +: WIDTH] = 32'h0;
    in_data[0*WIDTH +: WIDTH] = 32'hF0;
    in_data[2*WIDTH +: WIDTH] = 32'h0F;
    in_data[1*WIDTH +: WIDTH] = 32'h1234_0000;
    sel = 4'b0101; in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
    @(posedge clk); @(negedge clk);
    checkOutput("oh_multi", 1'b1, 32'hFF, 2'd0, 1'b1);
    sel = 4'b0000;
    @(posedge clk); @(negedge clk);
    checkOutput("oh_zero", 1'b1, 32'h0, 2'd0, 1'b1);
    sel = 4'b1100; in_data[3*WIDTH +: WIDTH] = 32'h100;
    @(posedge clk); @(negedge clk);
    checkOutput("oh_high", 1'b1, 32'h10F, 2'd2, 1'b1);
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule

// File: doc/mux_skid_sel.md
# mux_skid_sel

Parametrised N-channel select mux with a registered, 2-entry skid-buffered output and valid/ready handshakes on both sides. It replaces the plain 2:1 combinational select wherever a pipeline stage must choose between several operand or result sources and also absorb downstream back-pressure (hazard-unit stall) without dropping or duplicating a transfer. It sits between a stage's source candidates and the next pipeline register; flush support lets the hazard unit squash in-flight entries on a branch or jump.

## Interface
Parameters:
- WIDTH, 32, data width of every channel and of out_data.
- SEL_W, 2, binary select width; channel count CH = 2**SEL_W.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous squash of all buffered entries.
- in_data  input  CH*WIDTH  channel i at [i*WIDTH +: WIDTH].
- sel  input  SEL_W  binary channel select, sampled on accept (CH bits one-hot with MUX_SKID_ONEHOT_EN).
- in_valid  input  1  upstream offers a transfer.
- in_ready  output  1  block can accept this cycle.
- out_data  output  WIDTH  selected data at head of buffer.
- out_sel  output  SEL_W  binary index of the channel that produced out_data.
- out_valid  output  1  out_data/out_sel are valid.
- out_ready  input  1  downstream consumes the head this cycle.

## Operation
- Accept = in_valid & in_ready & !rst & !flush. On accept, in_data[sel] and sel are captured; sel is don't-care otherwise.
- Pop = out_valid & out_ready.
- Storage: main register (drives outputs) + skid register. State machine on occupancy:
  - EMPTY: accept → ONE (main loads). Else stay.
  - ONE: accept & pop → ONE (main loads new); accept only → TWO (skid loads); pop only → EMPTY; neither → stay.
  - TWO: pop → ONE (main ← skid); else stay. No accept possible.
- in_ready = (state != TWO); driven from registered state only, no combinational path from out_ready.
- out_valid = (state != EMPTY).
- Order strictly FIFO; no transfer lost or duplicated.
- flush: next state EMPTY; overrides a same-cycle accept and pop (pop still counts as consumed by downstream). Register contents need not be cleared but outputs must show out_valid=0.
- rst: state EMPTY; out_valid=0, out_data=0, out_sel=0, in_ready=1 from the first cycle after reset. rst mid-transfer discards both entries. rst has priority over flush.

## Timing
- Latency: data accepted at edge k is on out_data with out_valid=1 after edge k (1 cycle).
- Throughput: 1 transfer/cycle with out_ready held high.
- While out_valid=1 and out_ready=0, out_data and out_sel hold stable until pop, flush or rst.
- in_ready falls one edge after the accept that fills the skid; rises one edge after the pop from TWO.
- Upstream may deassert in_valid or change sel/in_data any cycle; only accept-cycle values matter.

## Configuration
- MUX_SKID_ONEHOT_EN defined: sel is CH bits, one-hot. Selection is AND-OR across channels, so all-zero sel captures 0 and multi-hot captures the bitwise OR of the selected channels. out_sel = index of the lowest set bit (0 if none).
- Not defined: sel is SEL_W-bit binary; out_sel = captured sel.

## Test plan
- Reset: rst high 2 cycles with in_valid=1 → out_valid=0, out_data=0, out_sel=0, in_ready=1 after release; nothing captured.
- Streaming: WIDTH=32, SEL_W=2, out_ready=1; accept 0xA0,0xB1,0xC2,0xD3 from ch 0..3 on consecutive cycles → same values, out_sel 0..3, one cycle later, no bubbles.
- Back-pressure: out_ready=0, offer 0x11 then 0x22 → in_ready=0 after the second accept, 0x33 held off; out_ready=1 → 0x11, 0x22, 0x33 in order.
- Flush: buffer in TWO (0x44, 0x55), assert flush with in_valid=1 carrying 0x66 → next cycle out_valid=0, in_ready=1, 0x66 never appears.
- Simultaneous accept+pop in ONE: head 0x77, accept 0x88 with out_ready=1 → next cycle out_data=0x88, state ONE, in_ready=1.
- MUX_SKID_ONEHOT_EN: sel=4'b0101, ch0=0xF0, ch2=0x0F → out_data=0xFF, out_sel=0; sel=4'b0000 → out_data=0.
